// File: rtl/load_wb_align_unit.sv
// load_wb_align_unit: writeback stage that passes ALU results through or
// performs a load (byte/half/word/XLEN), aligning and extending the data.
//
// Optional feature macro: LOAD_WB_MISALIGN_SPLIT_EN
//   defined   -> word-crossing loads are split into two aligned reads
//   undefined -> word-crossing loads are rejected with misalign_err
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          request handshake (ready only in IDLE)
//   wb_sel, alu_result, rd_in  request payload
//   mem_req/mem_addr/mem_gnt   aligned read request channel
//   mem_rvalid/mem_rdata       read response channel
//   wb_valid/wb_data/wb_rd     registered writeback pulse and payload
//   misalign_err               rejected misaligned access (with wb_valid)
module load_wb_align_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      wb_sel,
    input  logic [XLEN-1:0] alu_result,
    input  logic [4:0]      rd_in,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      wb_rd,
    output logic            misalign_err
);

    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned OW = $clog2(NB);

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        WAIT0,
`ifdef LOAD_WB_MISALIGN_SPLIT_EN
        REQ1,
        WAIT1,
`endif
        RESP
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      sel_q, sel_d;
    logic [OW-1:0]   off_q, off_d;
    logic [4:0]      rd_q, rd_d;
    logic            in_ready_q, in_ready_d;
    logic            mem_req_q, mem_req_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic            wb_valid_q, wb_valid_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic            err_q, err_d;
    logic            cross_in;
`ifdef LOAD_WB_MISALIGN_SPLIT_EN
    logic [XLEN-1:0] rdata0_q, rdata0_d;
    logic            cross_q;
`endif

    // Access size in bytes; on XLEN=32 the word loads are full-width loads.
    function automatic logic [3:0] acc_size(input logic [2:0] sel);
        logic [3:0] sz;
        case (sel)
            3'b010, 3'b100: sz = 4'd1;
            3'b011, 3'b101: sz = 4'd2;
            3'b110, 3'b111: sz = (XLEN == 32) ? 4'(NB) : 4'd4;
            default:        sz = 4'(NB);
        endcase
        return sz;
    endfunction

    // True when the access spills past the end of the aligned word.
    function automatic logic crosses(input logic [OW-1:0] off, input logic [2:0] sel);
        return (5'(off) + 5'(acc_size(sel))) > 5'(NB);
    endfunction

    // Shift the addressed bytes down to bit 0 and extend per load type.
    function automatic logic [XLEN-1:0] extract(input logic [2*XLEN-1:0] pair,
                                                input logic [OW-1:0]     off,
                                                input logic [2:0]        sel);
        logic [2*XLEN-1:0] sh;
        logic [XLEN-1:0]   res;
        sh = pair >> {off, 3'b000};
        case (sel)
            3'b010:  res = XLEN'($signed(sh[7:0]));
            3'b100:  res = XLEN'(sh[7:0]);
            3'b011:  res = XLEN'($signed(sh[15:0]));
            3'b101:  res = XLEN'(sh[15:0]);
            3'b110:  res = (XLEN == 64) ? XLEN'($signed(sh[31:0])) : sh[XLEN-1:0];
            3'b111:  res = (XLEN == 64) ? XLEN'(sh[31:0]) : sh[XLEN-1:0];
            default: res = sh[XLEN-1:0];
        endcase
        return res;
    endfunction

    assign cross_in = crosses(alu_result[OW-1:0], wb_sel);
`ifdef LOAD_WB_MISALIGN_SPLIT_EN
    assign cross_q  = crosses(off_q, sel_q);
`endif

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        off_d      = off_q;
        rd_d       = rd_q;
        mem_req_d  = 1'b0;
        mem_addr_d = mem_addr_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        err_d      = err_q;
`ifdef LOAD_WB_MISALIGN_SPLIT_EN
        rdata0_d   = rdata0_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    sel_d = wb_sel;
                    off_d = alu_result[OW-1:0];
                    rd_d  = rd_in;
                    if (wb_sel == 3'b000) begin
                        state_d    = RESP;
                        wb_valid_d = 1'b1;
                        wb_data_d  = alu_result;
                        wb_rd_d    = rd_in;
                        err_d      = 1'b0;
                    end
`ifndef LOAD_WB_MISALIGN_SPLIT_EN
                    else if (cross_in) begin
                        state_d    = RESP;
                        wb_valid_d = 1'b1;
                        wb_data_d  = '0;
                        wb_rd_d    = rd_in;
                        err_d      = 1'b1;
                    end
`endif
                    else begin
                        state_d    = REQ0;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {alu_result[XLEN-1:OW], OW'(0)};
                    end
                end
            end
            REQ0: begin
                mem_req_d = 1'b1;
                if (mem_gnt) begin
                    state_d   = WAIT0;
                    mem_req_d = 1'b0;
                end
            end
            WAIT0: begin
                if (mem_rvalid) begin
`ifdef LOAD_WB_MISALIGN_SPLIT_EN
                    if (cross_q) begin
                        state_d    = REQ1;
                        rdata0_d   = mem_rdata;
                        mem_req_d  = 1'b1;
                        mem_addr_d = mem_addr_q + XLEN'(NB);
                    end else
`endif
                    begin
                        state_d    = RESP;
                        wb_valid_d = 1'b1;
                        wb_data_d  = extract({{XLEN{1'b0}}, mem_rdata}, off_q, sel_q);
                        wb_rd_d    = rd_q;
                        err_d      = 1'b0;
                    end
                end
            end
`ifdef LOAD_WB_MISALIGN_SPLIT_EN
            REQ1: begin
                mem_req_d = 1'b1;
                if (mem_gnt) begin
                    state_d   = WAIT1;
                    mem_req_d = 1'b0;
                end
            end
            WAIT1: begin
                if (mem_rvalid) begin
                    state_d    = RESP;
                    wb_valid_d = 1'b1;
                    wb_data_d  = extract({mem_rdata, rdata0_q}, off_q, sel_q);
                    wb_rd_d    = rd_q;
                    err_d      = 1'b0;
                end
            end
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= 3'b000;
            off_q      <= '0;
            rd_q       <= 5'd0;
            in_ready_q <= 1'b1;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= 5'd0;
            err_q      <= 1'b0;
`ifdef LOAD_WB_MISALIGN_SPLIT_EN
            rdata0_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            off_q      <= off_d;
            rd_q       <= rd_d;
            in_ready_q <= in_ready_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            err_q      <= err_d;
`ifdef LOAD_WB_MISALIGN_SPLIT_EN
            rdata0_q   <= rdata0_d;
`endif
        end
    end

    assign in_ready     = in_ready_q;
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign wb_valid     = wb_valid_q;
    assign wb_data      = wb_data_q;
    assign wb_rd        = wb_rd_q;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_load_wb_align_unit.sv
// Directed, table-driven bench for load_wb_align_unit at XLEN=32.
// Expectations for word-crossing loads follow LOAD_WB_MISALIGN_SPLIT_EN.
module tb_load_wb_align_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  wb_sel;
    logic [31:0] alu_result;
    logic [4:0]  rd_in;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        misalign_err;

    int total = 0;
    int bad   = 0;

    load_wb_align_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .wb_sel(wb_sel), .alu_result(alu_result), .rd_in(rd_in),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = immediate writeback (ALU or rejected), 1 = one read, 2 = two reads
    typedef struct {
        logic [2:0]  sel;
        logic [31:0] addr;
        logic [4:0]  rd;
        logic [1:0]  kind;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [31:0] ea0;
        logic [31:0] ea1;
        logic [31:0] edata;
        logic        eerr;
    } vec_t;

    localparam int NV = 15;
    vec_t vt[NV];

    function automatic vec_t mk(input logic [2:0] sel, input logic [31:0] addr,
                                input logic [4:0] rd, input logic [1:0] kind,
                                input logic [31:0] rd0, input logic [31:0] rd1,
                                input logic [31:0] ea0, input logic [31:0] ea1,
                                input logic [31:0] edata, input logic eerr);
        vec_t v;
        v.sel = sel; v.addr = addr; v.rd = rd; v.kind = kind;
        v.rd0 = rd0; v.rd1 = rd1; v.ea0 = ea0; v.ea1 = ea1;
        v.edata = edata; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Drive one request through the unit, acting as the memory.
    task automatic run(input int i, input vec_t v);
        @(negedge clk);
        chk($sformatf("v%0d_in_ready_idle", i), 32'(in_ready), 32'd1);
        in_valid = 1'b1; wb_sel = v.sel; alu_result = v.addr; rd_in = v.rd;
        @(negedge clk);
        in_valid = 1'b0;
        if (v.kind != 2'd0) begin
            chk($sformatf("v%0d_req0", i), 32'(mem_req), 32'd1);
            chk($sformatf("v%0d_addr0", i), mem_addr, v.ea0);
            chk($sformatf("v%0d_busy", i), 32'(in_ready), 32'd0);
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
            chk($sformatf("v%0d_req_drop", i), 32'(mem_req), 32'd0);
            mem_rvalid = 1'b1; mem_rdata = v.rd0;
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (v.kind == 2'd2) begin
                chk($sformatf("v%0d_req1", i), 32'(mem_req), 32'd1);
                chk($sformatf("v%0d_addr1", i), mem_addr, v.ea1);
                mem_gnt = 1'b1;
                @(negedge clk);
                mem_gnt = 1'b0;
                mem_rvalid = 1'b1; mem_rdata = v.rd1;
                @(negedge clk);
                mem_rvalid = 1'b0;
            end
        end else begin
            chk($sformatf("v%0d_no_req", i), 32'(mem_req), 32'd0);
        end
        chk($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'd1);
        chk($sformatf("v%0d_wb_data", i), wb_data, v.edata);
        chk($sformatf("v%0d_wb_rd", i), 32'(wb_rd), 32'(v.rd));
        chk($sformatf("v%0d_err", i), 32'(misalign_err), 32'(v.eerr));
        chk($sformatf("v%0d_resp_ready", i), 32'(in_ready), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d_wb_drop", i), 32'(wb_valid), 32'd0);
        chk($sformatf("v%0d_data_hold", i), wb_data, v.edata);
        chk($sformatf("v%0d_err_hold", i), 32'(misalign_err), 32'(v.eerr));
        chk($sformatf("v%0d_ready_back", i), 32'(in_ready), 32'd1);
        chk($sformatf("v%0d_idle_no_req", i), 32'(mem_req), 32'd0);
    endtask

    initial begin
        vt[0]  = mk(3'b000, 32'h12345678, 5'd5,  2'd0, 0, 0, 0, 0, 32'h12345678, 1'b0);
        vt[1]  = mk(3'b010, 32'h00001003, 5'd1,  2'd1, 32'h80FF0000, 0, 32'h00001000, 0, 32'hFFFFFF80, 1'b0);
        vt[2]  = mk(3'b100, 32'h00001003, 5'd2,  2'd1, 32'h80FF0000, 0, 32'h00001000, 0, 32'h00000080, 1'b0);
        vt[3]  = mk(3'b011, 32'h00002002, 5'd3,  2'd1, 32'h80011234, 0, 32'h00002000, 0, 32'hFFFF8001, 1'b0);
        vt[4]  = mk(3'b101, 32'h00002002, 5'd4,  2'd1, 32'h80011234, 0, 32'h00002000, 0, 32'h00008001, 1'b0);
        vt[5]  = mk(3'b001, 32'h00003000, 5'd6,  2'd1, 32'hDEADBEEF, 0, 32'h00003000, 0, 32'hDEADBEEF, 1'b0);
        vt[6]  = mk(3'b110, 32'h00003004, 5'd7,  2'd1, 32'hCAFEF00D, 0, 32'h00003004, 0, 32'hCAFEF00D, 1'b0);
        vt[7]  = mk(3'b111, 32'h00003008, 5'd8,  2'd1, 32'h80000001, 0, 32'h00003008, 0, 32'h80000001, 1'b0);
        vt[8]  = mk(3'b010, 32'h00000010, 5'd9,  2'd1, 32'h0000007F, 0, 32'h00000010, 0, 32'h0000007F, 1'b0);
        vt[9]  = mk(3'b011, 32'h00000001, 5'd10, 2'd1, 32'h00FEDC00, 0, 32'h00000000, 0, 32'hFFFFFEDC, 1'b0);
`ifdef LOAD_WB_MISALIGN_SPLIT_EN
        vt[10] = mk(3'b011, 32'h00000003, 5'd11, 2'd2, 32'hAB000000, 32'h000000CD, 32'h0, 32'h4, 32'hFFFFCDAB, 1'b0);
        vt[11] = mk(3'b101, 32'h00000003, 5'd12, 2'd2, 32'hAB000000, 32'h000000CD, 32'h0, 32'h4, 32'h0000CDAB, 1'b0);
        vt[12] = mk(3'b110, 32'hFFFFFFFE, 5'd13, 2'd2, 32'h11223344, 32'h55667788, 32'hFFFFFFFC, 32'h0, 32'h77881122, 1'b0);
        vt[13] = mk(3'b001, 32'h00000001, 5'd14, 2'd2, 32'hAABBCCDD, 32'h11223344, 32'h0, 32'h4, 32'h44AABBCC, 1'b0);
`else
        vt[10] = mk(3'b011, 32'h00000003, 5'd11, 2'd0, 0, 0, 0, 0, 32'h0, 1'b1);
        vt[11] = mk(3'b101, 32'h00000003, 5'd12, 2'd0, 0, 0, 0, 0, 32'h0, 1'b1);
        vt[12] = mk(3'b110, 32'hFFFFFFFE, 5'd13, 2'd0, 0, 0, 0, 0, 32'h0, 1'b1);
        vt[13] = mk(3'b001, 32'h00000001, 5'd14, 2'd0, 0, 0, 0, 0, 32'h0, 1'b1);
`endif
        vt[14] = mk(3'b000, 32'hFFFFFFFF, 5'd31, 2'd0, 0, 0, 0, 0, 32'hFFFFFFFF, 1'b0);

        rst_n = 1'b0; in_valid = 1'b0; wb_sel = 3'b000; alu_result = '0; rd_in = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_err", 32'(misalign_err), 32'd0);

        for (int i = 0; i < NV; i++) run(i, vt[i]);

        // Late grant with held mem_req; rvalid outside WAIT0 and in_valid while busy are ignored.
        @(negedge clk);
        in_valid = 1'b1; wb_sel = 3'b100; alu_result = 32'h00001003; rd_in = 5'd20;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("slow_req_%0d", k), 32'(mem_req), 32'd1);
            chk($sformatf("slow_addr_%0d", k), mem_addr, 32'h00001000);
            chk($sformatf("slow_nowb_%0d", k), 32'(wb_valid), 32'd0);
            @(negedge clk);
        end
        mem_rvalid = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("slow_wait_nowb_%0d", k), 32'(wb_valid), 32'd0);
            chk($sformatf("slow_wait_noreq_%0d", k), 32'(mem_req), 32'd0);
            @(negedge clk);
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h80FF0000;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("slow_wb_valid", 32'(wb_valid), 32'd1);
        chk("slow_wb_data", wb_data, 32'h00000080);
        chk("slow_wb_rd", 32'(wb_rd), 32'd20);
        in_valid = 1'b0;
        @(negedge clk);
        chk("slow_wb_drop", 32'(wb_valid), 32'd0);
        chk("slow_ready", 32'(in_ready), 32'd1);

        // Reset while waiting for read data; a late rvalid must be ignored.
        @(negedge clk);
        in_valid = 1'b1; wb_sel = 3'b010; alu_result = 32'h00005003; rd_in = 5'd22;
        @(negedge clk);
        in_valid = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_req", 32'(mem_req), 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        chk("midrst_wb_data", wb_data, 32'd0);
        chk("midrst_wb_rd", 32'(wb_rd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h80FF0000;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("late_rv_wb_valid", 32'(wb_valid), 32'd0);
        chk("late_rv_mem_req", 32'(mem_req), 32'd0);
        chk("late_rv_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("late_rv_wb_valid2", 32'(wb_valid), 32'd0);
        chk("late_rv_wb_data", wb_data, 32'd0);

        // Unit still works after the abandoned transaction.
        run(NV, vt[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_wb_align_unit.md
LOAD_WB_ALIGN_UNIT -- requirements
Module: load_wb_align_unit

Interface
REQ-001 XLEN, 32, datapath width; SHALL be 32 or 64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  writeback request present.
REQ-005 in_ready  output  1  unit can accept a request; high only in IDLE.
REQ-006 wb_sel  input  3  000 ALU, 001 full XLEN load, 010 LB, 011 LH, 100 LBU, 101 LHU, 110 LW signed, 111 LWU.
REQ-007 alu_result  input  XLEN  ALU result; byte address when wb_sel != 000.
REQ-008 rd_in  input  5  destination register index.
REQ-009 mem_req  output  1  memory read request.
REQ-010 mem_addr  output  XLEN  word-aligned read address, low log2(XLEN/8) bits zero.
REQ-011 mem_gnt  input  1  request accepted this cycle.
REQ-012 mem_rvalid  input  1  read data valid.
REQ-013 mem_rdata  input  XLEN  read data word.
REQ-014 wb_valid  output  1  one-cycle writeback pulse.
REQ-015 wb_data  output  XLEN  writeback value, registered.
REQ-016 wb_rd  output  5  registered destination index.
REQ-017 misalign_err  output  1  qualified by wb_valid; misaligned access rejected.

Function
REQ-018 FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP; request accepted when in_valid && in_ready; wb_sel, alu_result, rd_in captured at acceptance.
REQ-019 wb_sel=000: IDLE->RESP; wb_valid asserts the cycle after acceptance with wb_data=alu_result.
REQ-020 Load: IDLE->REQ0; mem_req high throughout REQ0/REQ1 with stable mem_addr; mem_gnt moves REQx->WAITx.
REQ-021 mem_rvalid is sampled only in WAIT0/WAIT1; in any other state it is ignored.
REQ-022 Access size: byte for 010/100, half for 011/101, 4 bytes for 110/111, XLEN/8 for 001; XLEN=32 treats 110/111 as 001.
REQ-023 Offset = address mod XLEN/8; access crosses a word when offset+size > XLEN/8.
REQ-024 Non-crossing load: WAIT0 + mem_rvalid -> RESP; data = rdata0 >> (8*offset), then sign- or zero-extend per wb_sel.
REQ-025 RESP lasts exactly one cycle with wb_valid=1, then returns to IDLE; in_ready=0 in RESP.
REQ-026 Minimum load latency: acceptance N, mem_req N+1, wb_valid one cycle after the final mem_rvalid.
REQ-027 in_valid outside IDLE is ignored; the producer holds it.
REQ-028 wb_data/wb_rd/misalign_err hold their last values when wb_valid=0.

Reset
REQ-029 rst_n low SHALL force IDLE immediately: mem_req=0, mem_addr=0, wb_valid=0, wb_data=0, wb_rd=0, misalign_err=0, in_ready=1 after release.
REQ-030 Reset mid-transaction SHALL abandon it; a late mem_rvalid arriving in IDLE SHALL have no effect.

Configuration
REQ-031 Macro LOAD_WB_MISALIGN_SPLIT_EN, when defined: a crossing load SHALL go WAIT0->REQ1 on mem_rvalid, storing rdata0 and issuing a second read at the aligned address + XLEN/8, modulo 2^XLEN.
REQ-032 With the macro defined, WAIT1 + mem_rvalid -> RESP; data = {rdata1,rdata0} >> (8*offset), then extended; misalign_err=0.
REQ-033 Macro undefined: a crossing load SHALL issue no mem_req and go IDLE->RESP with wb_data=0 and misalign_err=1; REQ1/WAIT1 are not built.

Verification (XLEN=32)
REQ-034 wb_sel=000, alu_result=0x12345678, rd_in=5 -> next cycle wb_valid=1, wb_data=0x12345678, wb_rd=5, mem_req never high.
REQ-035 LB addr 0x00001003, rdata 0x80FF0000 -> mem_addr 0x00001000, wb_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-036 Split enabled: LH addr 0x00000003, rdata0 0xAB000000, rdata1 0x000000CD -> requests to 0x0 then 0x4, wb_data 0xFFFFCDAB; LHU -> 0x0000CDAB.
REQ-037 Split disabled, same LH -> no mem_req, wb_valid next cycle, misalign_err=1, wb_data=0.
REQ-038 Split enabled: LW addr 0xFFFFFFFE -> second mem_addr 0x00000000 (wrap).
REQ-039 rst_n pulsed low in WAIT0, then mem_rvalid=1 after release -> mem_req=0, wb_valid stays 0, in_ready=1.
